// File: rtl/rv32_multicycle_core.sv
// Minimal multi-cycle RV32I core: FETCH/EXEC controller sharing one valid/ready memory port
// for instruction fetch and load/store traffic. DATA_WIDTH must be 32.
module rv32_multicycle_core #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [31:0]           o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_wr_valid,
  input  logic                  i_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_rd_valid,
  output logic                  o_rd_ready,
  output logic                  o_invalid_inst
);

  typedef enum logic [2:0] {
    StFetch = 3'b000,
    StExec  = 3'b001
  } state_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] rf_q [32];

  logic        rf_we, rf_wr_en, exec_done, illegal, take_branch;
  logic [31:0] rf_wdata, pc_next;

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode  = inst_q[6:0];
  assign rd      = inst_q[11:7];
  assign funct3  = inst_q[14:12];
  assign rs1     = inst_q[19:15];
  assign rs2     = inst_q[24:20];
  assign funct7  = inst_q[31:25];
  assign rs1_val = rf_q[rs1];
  assign rs2_val = rf_q[rs2];

  assign imm_i = {{20{inst_q[31]}}, inst_q[31:20]};
  assign imm_s = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
  assign imm_b = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_u = {inst_q[31:12], 12'b0};
  assign imm_j = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu = alt ? a - b : a + b;
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'b0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  // Loads take the low lanes of the returned word; no byte-lane steering.
  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'b000:  load_ext = {{24{d[7]}}, d[7:0]};
      3'b001:  load_ext = {{16{d[15]}}, d[15:0]};
      3'b100:  load_ext = {24'b0, d[7:0]};
      3'b101:  load_ext = {16'b0, d[15:0]};
      default: load_ext = d;
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    o_addr         = pc_q;
    o_data         = '0;
    o_wr_valid     = 1'b0;
    o_rd_ready     = 1'b0;
    o_invalid_inst = 1'b0;
    rf_we          = 1'b0;
    rf_wdata       = '0;
    exec_done      = 1'b1;
    illegal        = 1'b0;
    take_branch    = 1'b0;
    pc_next        = pc_q + 32'd4;

    case (state_q)
      StFetch: begin
        o_rd_ready = 1'b1;
        if (i_rd_valid) begin
          inst_d  = i_data;
          state_d = StExec;
        end
      end
      StExec: begin
        case (opcode)
          OpLui: begin
            rf_we    = 1'b1;
            rf_wdata = imm_u;
          end
          OpAuipc: begin
            rf_we    = 1'b1;
            rf_wdata = pc_q + imm_u;
          end
          OpJal: begin
            rf_we    = 1'b1;
            rf_wdata = pc_q + 32'd4;
            pc_next  = pc_q + imm_j;
          end
          OpJalr: begin
            if (funct3 != 3'b000) begin
              illegal = 1'b1;
            end else begin
              rf_we    = 1'b1;
              rf_wdata = pc_q + 32'd4;
              pc_next  = (rs1_val + imm_i) & ~32'd1;
            end
          end
          OpBranch: begin
            case (funct3)
              3'b000:  take_branch = rs1_val == rs2_val;
              3'b001:  take_branch = rs1_val != rs2_val;
              3'b100:  take_branch = $signed(rs1_val) < $signed(rs2_val);
              3'b101:  take_branch = $signed(rs1_val) >= $signed(rs2_val);
              3'b110:  take_branch = rs1_val < rs2_val;
              3'b111:  take_branch = rs1_val >= rs2_val;
              default: illegal = 1'b1;
            endcase
            if (take_branch) pc_next = pc_q + imm_b;
          end
          OpImm: begin
            if ((funct3 == 3'b001 && funct7 != 7'b0) ||
                (funct3 == 3'b101 && funct7 != 7'b0 && funct7 != 7'b0100000)) begin
              illegal = 1'b1;
            end else begin
              rf_we    = 1'b1;
              rf_wdata = alu(rs1_val, imm_i, funct3, funct3 == 3'b101 && inst_q[30]);
            end
          end
          OpReg: begin
            if (funct7 == 7'b0 ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
              rf_we    = 1'b1;
              rf_wdata = alu(rs1_val, rs2_val, funct3, inst_q[30]);
            end else begin
              illegal = 1'b1;
            end
          end
          OpLoad: begin
            if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
              illegal = 1'b1;
            end else begin
              o_addr     = rs1_val + imm_i;
              o_rd_ready = 1'b1;
              exec_done  = i_rd_valid;
              rf_we      = 1'b1;
              rf_wdata   = load_ext(i_data, funct3);
            end
          end
          OpStore: begin
            if (funct3[2] || funct3 == 3'b011) begin
              illegal = 1'b1;
            end else begin
              o_addr     = rs1_val + imm_s;
              o_wr_valid = 1'b1;
              exec_done  = i_wr_ready;
              case (funct3)
                3'b000:  o_data = {24'b0, rs2_val[7:0]};
                3'b001:  o_data = {16'b0, rs2_val[15:0]};
                default: o_data = rs2_val;
              endcase
            end
          end
          OpFence, OpSystem: ;
          default: illegal = 1'b1;
        endcase
        o_invalid_inst = illegal;
        if (exec_done) begin
          state_d = StFetch;
          pc_d    = pc_next;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  assign rf_wr_en = rf_we && exec_done && (rd != 5'd0);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StFetch;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_wr_en) begin
      rf_q[rd] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_rv32_multicycle_core.sv
// Bench for rv32_multicycle_core: memory model driver plus a bus-event scoreboard checking
// fetch addresses, load addresses, store address/data and invalid-instruction flags.
module tb_rv32_multicycle_core;

  localparam int KRd  = 0;
  localparam int KWr  = 1;
  localparam int KInv = 2;
  localparam int RdWait = 1;
  localparam int WrWait = 2;
  localparam logic [31:0] BlockAddr = 32'h0000_072C;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] o_addr;
  logic [31:0] o_data;
  logic        o_wr_valid;
  logic        i_wr_ready;
  logic [31:0] i_data;
  logic        i_rd_valid;
  logic        o_rd_ready;
  logic        o_invalid_inst;

  logic [31:0] mem [0:4095];
  txn_t        exp_q [$];
  int          tests = 0;
  int          fails = 0;
  logic        mon_en = 1'b0;

  rv32_multicycle_core #(.DATA_WIDTH(32)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_addr        (o_addr),
    .o_data        (o_data),
    .o_wr_valid    (o_wr_valid),
    .i_wr_ready    (i_wr_ready),
    .i_data        (i_data),
    .i_rd_valid    (i_rd_valid),
    .o_rd_ready    (o_rd_ready),
    .o_invalid_inst(o_invalid_inst)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[13:2]] = word;
  endtask

  task automatic exp_push(input int kind, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t.kind = kind;
    t.addr = addr;
    t.data = data;
    exp_q.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_evt(input int kind, input logic [31:0] addr, input logic [31:0] data);
    txn_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL bus_evt: got kind=%0d addr=%h data=%h, expected no event", kind, addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr !== addr || (kind == KWr && e.data !== data)) begin
        fails++;
        $display("FAIL bus_evt: got kind=%0d addr=%h data=%h, expected kind=%0d addr=%h data=%h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Memory driver: one read wait state, two write wait states, stores to BlockAddr never accepted.
  initial begin
    int rd_cnt;
    int wr_cnt;
    rd_cnt = 0;
    wr_cnt = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        rd_cnt     = 0;
        wr_cnt     = 0;
        i_rd_valid = 1'b0;
        i_wr_ready = 1'b0;
      end else begin
        rd_cnt     = o_rd_ready ? rd_cnt + 1 : 0;
        wr_cnt     = o_wr_valid ? wr_cnt + 1 : 0;
        i_data     = mem[o_addr[13:2]];
        i_rd_valid = o_rd_ready && rd_cnt > RdWait;
        i_wr_ready = o_wr_valid && wr_cnt > WrWait && o_addr != BlockAddr;
        if (i_rd_valid) rd_cnt = 0;
        if (i_wr_ready) wr_cnt = 0;
      end
    end
  end

  // Monitor: every handshake or invalid flag is popped against the scoreboard.
  initial begin
    logic        wr_pend;
    logic [31:0] pend_addr;
    logic [31:0] pend_data;
    wr_pend = 1'b0;
    pend_addr = '0;
    pend_data = '0;
    forever begin
      @(negedge i_clk);
      #1;
      if (mon_en && i_rst) begin
        if (o_invalid_inst) check_evt(KInv, o_addr, 32'h0);
        if (o_rd_ready && i_rd_valid) check_evt(KRd, o_addr, 32'h0);
        if (o_wr_valid && i_wr_ready) check_evt(KWr, o_addr, o_data);
        if (wr_pend) begin
          chk("store_hold_valid", {31'b0, o_wr_valid}, 32'h1);
          chk("store_hold_addr", o_addr, pend_addr);
          chk("store_hold_data", o_data, pend_data);
        end
        wr_pend   = o_wr_valid && !i_wr_ready;
        pend_addr = o_addr;
        pend_data = o_data;
      end
    end
  end

  initial begin
    i_rst      = 1'b0;
    i_rd_valid = 1'b0;
    i_wr_ready = 1'b0;
    i_data     = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h180] = 32'h1234_5680;

    put(32'h00, enc_i(12'd11, 5'd0, 3'b000, 5'd1, 7'b0010011));   // addi x1,x0,11
    put(32'h04, enc_i(12'd55, 5'd0, 3'b000, 5'd2, 7'b0010011));   // addi x2,x0,55
    put(32'h08, enc_b(13'h0FFE, 5'd1, 5'd2, 3'b100));             // blt x2,x1 (not taken)
    put(32'h0C, enc_b(13'h0FFE, 5'd2, 5'd1, 3'b100));             // blt x1,x2 -> 0x100A
    put(32'h100A, enc_j(21'h1FF036, 5'd8));                       // jal x8,-0xFCA -> 0x40
    put(32'h40, {20'hAABBC, 5'd5, 7'b0110111});                   // lui x5
    put(32'h44, enc_s(12'h7BC, 5'd5, 5'd0, 3'b001));              // sh x5,0x7BC
    put(32'h48, enc_s(12'h700, 5'd8, 5'd0, 3'b010));              // sw x8
    put(32'h4C, 32'h0000_007F);                                   // undefined opcode
    put(32'h50, enc_i(12'h600, 5'd0, 3'b000, 5'd3, 7'b0000011));  // lb x3
    put(32'h54, enc_i(12'h600, 5'd0, 3'b100, 5'd4, 7'b0000011));  // lbu x4
    put(32'h58, enc_s(12'h704, 5'd3, 5'd0, 3'b010));
    put(32'h5C, enc_s(12'h708, 5'd4, 5'd0, 3'b010));
    put(32'h60, enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011));    // addi x0,x0,5
    put(32'h64, enc_s(12'h70C, 5'd0, 5'd0, 3'b010));
    put(32'h68, enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd6));     // sub x6,x1,x2
    put(32'h6C, enc_i(12'h404, 5'd5, 3'b101, 5'd7, 7'b0010011));  // srai x7,x5,4
    put(32'h70, enc_r(7'b0, 5'd2, 5'd1, 3'b011, 5'd9));           // sltu x9,x1,x2
    put(32'h74, {20'h00001, 5'd10, 7'b0010111});                  // auipc x10,1
    put(32'h78, enc_s(12'h710, 5'd6, 5'd0, 3'b010));
    put(32'h7C, enc_s(12'h714, 5'd7, 5'd0, 3'b010));
    put(32'h80, enc_s(12'h718, 5'd9, 5'd0, 3'b010));
    put(32'h84, enc_s(12'h71C, 5'd10, 5'd0, 3'b010));
    put(32'h88, enc_i(12'h0C1, 5'd0, 3'b000, 5'd11, 7'b1100111)); // jalr x11,0xC1(x0)
    put(32'hC0, enc_s(12'h720, 5'd11, 5'd0, 3'b010));
    put(32'hC4, 32'h0000_000F);                                   // fence
    put(32'hC8, enc_s(12'h724, 5'd3, 5'd0, 3'b000));              // sb x3
    put(32'hCC, enc_s(12'h728, 5'd3, 5'd0, 3'b001));              // sh x3
    put(32'hD0, enc_s(12'h72C, 5'd5, 5'd0, 3'b010));              // sw x5, never accepted

    exp_push(KRd, 32'h00, 0);
    exp_push(KRd, 32'h04, 0);
    exp_push(KRd, 32'h08, 0);
    exp_push(KRd, 32'h0C, 0);
    exp_push(KRd, 32'h100A, 0);
    exp_push(KRd, 32'h40, 0);
    exp_push(KRd, 32'h44, 0);
    exp_push(KWr, 32'h7BC, 32'h0000_C000);
    exp_push(KRd, 32'h48, 0);
    exp_push(KWr, 32'h700, 32'h0000_100E);
    exp_push(KRd, 32'h4C, 0);
    exp_push(KInv, 32'h4C, 0);
    exp_push(KRd, 32'h50, 0);
    exp_push(KRd, 32'h600, 0);
    exp_push(KRd, 32'h54, 0);
    exp_push(KRd, 32'h600, 0);
    exp_push(KRd, 32'h58, 0);
    exp_push(KWr, 32'h704, 32'hFFFF_FF80);
    exp_push(KRd, 32'h5C, 0);
    exp_push(KWr, 32'h708, 32'h0000_0080);
    exp_push(KRd, 32'h60, 0);
    exp_push(KRd, 32'h64, 0);
    exp_push(KWr, 32'h70C, 32'h0000_0000);
    exp_push(KRd, 32'h68, 0);
    exp_push(KRd, 32'h6C, 0);
    exp_push(KRd, 32'h70, 0);
    exp_push(KRd, 32'h74, 0);
    exp_push(KRd, 32'h78, 0);
    exp_push(KWr, 32'h710, 32'hFFFF_FFD4);
    exp_push(KRd, 32'h7C, 0);
    exp_push(KWr, 32'h714, 32'hFAAB_BC00);
    exp_push(KRd, 32'h80, 0);
    exp_push(KWr, 32'h718, 32'h0000_0001);
    exp_push(KRd, 32'h84, 0);
    exp_push(KWr, 32'h71C, 32'h0000_1074);
    exp_push(KRd, 32'h88, 0);
    exp_push(KRd, 32'hC0, 0);
    exp_push(KWr, 32'h720, 32'h0000_008C);
    exp_push(KRd, 32'hC4, 0);
    exp_push(KRd, 32'hC8, 0);
    exp_push(KWr, 32'h724, 32'h0000_0080);
    exp_push(KRd, 32'hCC, 0);
    exp_push(KWr, 32'h728, 32'h0000_FF80);
    exp_push(KRd, 32'hD0, 0);

    repeat (2) @(negedge i_clk);
    #1;
    chk("reset_addr", o_addr, 32'h0);
    chk("reset_rd_ready", {31'b0, o_rd_ready}, 32'h1);
    chk("reset_wr_valid", {31'b0, o_wr_valid}, 32'h0);
    chk("reset_invalid", {31'b0, o_invalid_inst}, 32'h0);

    i_rst  = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 2000 && exp_q.size() != 0; c++) @(negedge i_clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d bus events still pending, expected 0", exp_q.size());
    end

    repeat (4) @(negedge i_clk);
    #1;
    chk("stalled_store_valid", {31'b0, o_wr_valid}, 32'h1);
    chk("stalled_store_addr", o_addr, 32'h0000_072C);
    chk("stalled_store_data", o_data, 32'hAABB_C000);

    mon_en = 1'b0;
    #1;
    i_rst = 1'b0;
    #1;
    chk("abort_wr_valid", {31'b0, o_wr_valid}, 32'h0);
    chk("abort_addr", o_addr, 32'h0);
    chk("abort_rd_ready", {31'b0, o_rd_ready}, 32'h1);
    chk("abort_invalid", {31'b0, o_invalid_inst}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
